// File: rtl/alu_share_arbiter_if.sv
// Requester-facing bundle for alu_share_arbiter: two request ports and a shared response bus.
// The master side belongs to the requesters; the slave side belongs to the arbiter.
interface alu_share_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_status;

    modport master (
        output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_status
    );

    modport slave (
        input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_status
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters using round-robin arbitration.
// MUL and DIV hold the ALU inputs for several cycles; the result goes back over a valid/ready response.
module alu_share_arbiter #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus,
    output logic [3:0]          alu_control,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_result,
    input  logic [7:0]          alu_status,
    output logic                busy
);

    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        owner;
    logic        win;
    logic        grant_any;
    logic        accept;
    logic        handshake;
    logic [3:0]  counter;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  load_count;

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        grant_any = |bus.req_valid;
        win       = 1'b0;
        if (bus.req_valid == 2'b11) begin
            win = ~last_grant;
        end else if (bus.req_valid[1]) begin
            win = 1'b1;
        end
    end

    always_comb begin
        sel_op = win ? bus.req1_op : bus.req0_op;
        sel_a  = win ? bus.req1_a  : bus.req0_a;
        sel_b  = win ? bus.req1_b  : bus.req0_b;
        if (sel_op == OP_MUL) begin
            load_count = MUL_LOAD;
        end else if (sel_op == OP_DIV) begin
            load_count = DIV_LOAD;
        end else begin
            load_count = 4'd0;
        end
    end

    assign accept    = (state == IDLE) && grant_any;
    assign handshake = (state == RESP) && (|(bus.rsp_valid & bus.rsp_ready));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready only ever points at the current winner, and only while idle.
    always_comb begin
        state_next    = state;
        bus.req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    bus.req_ready = win ? 2'b10 : 2'b01;
                    state_next    = EXEC;
                end
            end
            EXEC: begin
                if (counter == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands stay latched after completion so the ALU inputs do not toggle while idle.
    // rsp_valid rises one cycle after entering RESP, giving an N+1 cycle accept-to-response latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_control    <= 4'd0;
            alu_a          <= 32'd0;
            alu_b          <= 32'd0;
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            counter        <= 4'd0;
            bus.rsp_valid  <= 2'b00;
            bus.rsp_result <= 32'd0;
            bus.rsp_status <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_control <= sel_op;
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        owner       <= win;
                        counter     <= load_count;
                    end
                end
                EXEC: begin
                    if (counter == 4'd0) begin
                        bus.rsp_result <= alu_result;
                        bus.rsp_status <= alu_status;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    if (handshake) begin
                        bus.rsp_valid <= 2'b00;
                        last_grant    <= owner;
                    end else begin
                        bus.rsp_valid <= owner ? 2'b10 : 2'b01;
                    end
                end
                default: begin
                    bus.rsp_valid <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU standing in for the shared unit.
// Expected results are hand-computed constants for each vector.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  alu_control;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;
    logic        busy;
    logic [32:0] sum;
    logic signed [63:0] prod;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();

    alu_share_arbiter #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_control(alu_control),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .busy       (busy)
    );

    // Stand-in ALU: 0 AND, 1 OR, 2 ADD, 6 SUB, 5 MUL, 4 DIV; other codes return zero.
    always_comb begin
        alu_result = 32'd0;
        alu_status = 8'd0;
        sum        = 33'd0;
        prod       = 64'sd0;
        case (alu_control)
            4'd0: alu_result = alu_a & alu_b;
            4'd1: alu_result = alu_a | alu_b;
            4'd2: begin
                sum           = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result    = sum[31:0];
                alu_status[5] = sum[32];
            end
            4'd6: alu_result = alu_a - alu_b;
            4'd5: begin
                prod          = $signed(alu_a) * $signed(alu_b);
                alu_result    = prod[31:0];
                alu_status[6] = (prod != {{32{prod[31]}}, prod[31:0]});
            end
            4'd4: begin
                if (alu_b == 32'd0) begin
                    alu_status[2] = 1'b1;
                end else begin
                    alu_result = $signed(alu_a) / $signed(alu_b);
                end
            end
            default: alu_result = 32'd0;
        endcase
        alu_status[7] = (alu_result == 32'd0);
        alu_status[4] = alu_result[31];
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready))
        else $display("[TB] FAIL assert_onehot_ready: req_ready=%b, want at most one bit set", bus.req_ready);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            bus.req0_op = op;
            bus.req0_a  = a;
            bus.req0_b  = b;
        end else begin
            bus.req1_op = op;
            bus.req1_a  = a;
            bus.req1_b  = b;
        end
        bus.req_valid[port] = 1'b1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Counts edges from the accept edge until rsp_valid is seen, with a bound.
    task automatic waitResponse(output int cycles);
        cycles = 0;
        while (bus.rsp_valid == 2'b00 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic serve(input int port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic [7:0] stat, input string tag);
        int c;
        logic [1:0] own;
        own           = (port == 0) ? 2'b01 : 2'b10;
        bus.rsp_ready = 2'b11;
        applyStimulus(port, op, a, b);
        #1;
        checkOutput({tag, "_ready"}, {30'd0, bus.req_ready}, {30'd0, own});
        @(negedge clk);
        bus.req_valid[port] = 1'b0;
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
        waitResponse(c);
        checkOutput({tag, "_latency"}, c, lat);
        checkOutput({tag, "_rsp_valid"}, {30'd0, bus.rsp_valid}, {30'd0, own});
        checkOutput({tag, "_result"}, bus.rsp_result, res);
        checkOutput({tag, "_status"}, {24'd0, bus.rsp_status}, {24'd0, stat});
        @(negedge clk);
        checkOutput({tag, "_rsp_done"}, {30'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        int c;
        int n;
        logic [1:0] taken;
        logic [3:0] ops [4];
        logic seen_rsp;

        ops = '{4'd0, 4'd2, 4'd6, 4'd15};
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;

        doReset();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_alu_ctl", {28'd0, alu_control}, 32'd0);
        checkOutput("reset_alu_a", alu_a, 32'd0);
        checkOutput("reset_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        checkOutput("reset_req_ready", {30'd0, bus.req_ready}, 32'd0);

        serve(0, 4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2, 32'h00F0_00F0, 8'h00, "t1_and");

        // Both requesters valid straight out of reset.
        doReset();
        bus.rsp_ready = 2'b11;
        applyStimulus(0, 4'd2, 32'd5, 32'd7);
        applyStimulus(1, 4'd6, 32'd3, 32'd3);
        #1;
        checkOutput("t2_first_grant", {30'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        checkOutput("t2_alu_ctl", {28'd0, alu_control}, 32'd2);
        checkOutput("t2_alu_a", alu_a, 32'd5);
        checkOutput("t2_alu_b", alu_b, 32'd7);
        checkOutput("t2_no_ready_busy", {30'd0, bus.req_ready}, 32'd0);
        waitResponse(c);
        checkOutput("t2_add_latency", c, 2);
        checkOutput("t2_add_owner", {30'd0, bus.rsp_valid}, 32'd1);
        checkOutput("t2_add_result", bus.rsp_result, 32'd12);
        @(negedge clk);
        #1;
        checkOutput("t2_second_grant", {30'd0, bus.req_ready}, 32'd2);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        waitResponse(c);
        checkOutput("t2_sub_owner", {30'd0, bus.rsp_valid}, 32'd2);
        checkOutput("t2_sub_result", bus.rsp_result, 32'd0);
        checkOutput("t2_sub_status", {24'd0, bus.rsp_status}, 32'h80);
        @(negedge clk);

        bus.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            #1;
            while (bus.req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            checkOutput("t2_alternate", {30'd0, bus.req_ready}, (i % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        waitIdle();

        serve(1, 4'd5, 32'h0001_0000, 32'h0001_0000, 3, 32'd0, 8'hC0, "t3_mul");
        serve(0, 4'd4, 32'hFFFF_FFEC, 32'd3, 9, 32'hFFFF_FFFA, 8'h10, "t3_div");

        // Held response with the other port waiting and its own rsp_ready asserted.
        bus.rsp_ready = 2'b00;
        applyStimulus(1, 4'd4, 32'd9, 32'd0);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        applyStimulus(0, 4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        bus.rsp_ready = 2'b01;
        waitResponse(c);
        checkOutput("t4_div0_latency", c, 9);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t4_hold_valid", {30'd0, bus.rsp_valid}, 32'd2);
            checkOutput("t4_hold_result", bus.rsp_result, 32'd0);
            checkOutput("t4_hold_status", {24'd0, bus.rsp_status}, 32'h84);
            checkOutput("t4_hold_no_ready", {30'd0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        checkOutput("t4_rsp_cleared", {30'd0, bus.rsp_valid}, 32'd0);
        checkOutput("t4_pending_grant", {30'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        waitResponse(c);
        checkOutput("t4_and_result", bus.rsp_result, 32'h0F00_0F00);
        checkOutput("t4_and_owner", {30'd0, bus.rsp_valid}, 32'd1);
        @(negedge clk);

        // Reset in the fourth EXEC cycle of a divide.
        bus.rsp_ready = 2'b11;
        applyStimulus(1, 4'd4, 32'd100, 32'd7);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_alu_ctl", {28'd0, alu_control}, 32'd0);
        checkOutput("t5_alu_a", alu_a, 32'd0);
        checkOutput("t5_alu_b", alu_b, 32'd0);
        checkOutput("t5_rsp_result", bus.rsp_result, 32'd0);
        checkOutput("t5_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_rsp = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) seen_rsp = 1'b1;
        end
        checkOutput("t5_no_response", {31'd0, seen_rsp}, 32'd0);
        applyStimulus(0, 4'd15, 32'd1, 32'd2);
        applyStimulus(1, 4'd2, 32'd1, 32'd2);
        #1;
        checkOutput("t5_grant_after_reset", {30'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 2'b00;

        serve(0, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 2, 32'd0, 8'h80, "t6_op15");

        // Random traffic: requesters hold their op until accepted.
        taken = 2'b00;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (taken[p]) begin
                    bus.req_valid[p] = 1'b0;
                end else if (!bus.req_valid[p] && $urandom_range(0, 1) == 1) begin
                    applyStimulus(p, ops[$urandom_range(0, 3)], $urandom, $urandom);
                end
            end
            bus.rsp_ready = 2'($urandom_range(0, 3));
            #1;
            checkOutput("t6_onehot_ready", {31'd0, $onehot0(bus.req_ready)}, 32'd1);
            checkOutput("t6_ready_needs_valid", {30'd0, bus.req_ready & ~bus.req_valid}, 32'd0);
            taken = bus.req_ready & bus.req_valid;
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
